// File: rtl/jnwtr_ckmon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jnwtr_ckmon_pkg
// Purpose  : Shared types and constants for the jnwtr_ckmon clock-period
//            monitor: FSM state encoding, default counter width and the
//            saturation-max helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package jnwtr_ckmon_pkg;

  // Default width of the period counter and of PERIOD/PMIN/PMAX.
  localparam int CNT_W_DEF = 16;

  // Measurement FSM states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_MEAS = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // All-ones value of a w-bit counter, returned in 32 bits.
  function automatic logic [31:0] sat_max(input int unsigned w);
    if (w >= 32) begin
      return '1;
    end
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jnwtr_ckmon_sync.sv
`default_nettype none
// ============================================================================
// Module   : jnwtr_ckmon_sync
// Purpose  : Multi-flop synchronizer for an asynchronous level or strobe,
//            followed by a rising-edge detector producing a one-cycle pulse.
// Ports    : ck       - destination clock (rising edge)
//            rst      - asynchronous active-high reset
//            din      - asynchronous input
//            edge_det - one-cycle pulse on each synchronized rising edge
// Revision : 1.0 - initial release
// ============================================================================
module jnwtr_ckmon_sync
  import jnwtr_ckmon_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic ck,
  input  logic rst,
  input  logic din,
  output logic edge_det
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // Both terms come from flops, so the pulse is glitch-free.
  assign edge_det = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/jnwtr_ckmon.sv
`default_nettype none
// ============================================================================
// Module   : jnwtr_ckmon
// Purpose  : Measures the period of an asynchronous divided clock (cki) in
//            reference-clock cycles and checks it against [pmin, pmax].
//            Optional build macro JNWTR_CKMON_AVG_EN: each result averages
//            2^AVG_LOG2 consecutive periods.
// Ports    : ck, rst          - reference clock, async active-high reset
//            cki              - monitored clock (asynchronous)
//            start/cont/abort - measurement control
//            pmin, pmax       - inclusive window bounds
//            period           - last measured period
//            valid            - one-cycle result strobe
//            inrange, ovf     - window status / saturation of last result
//            busy             - FSM not idle
// Revision : 1.0 - initial release
// ============================================================================
module jnwtr_ckmon
  import jnwtr_ckmon_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int AVG_LOG2    = 2
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             cki,
  input  logic             start,
  input  logic             cont,
  input  logic             abort,
  input  logic [CNT_W-1:0] pmin,
  input  logic [CNT_W-1:0] pmax,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             inrange,
  output logic             ovf,
  output logic             busy
);

  localparam logic [1:0] c_idle = S_IDLE;
  localparam logic [1:0] c_arm  = S_ARM;
  localparam logic [1:0] c_meas = S_MEAS;
  localparam logic [1:0] c_done = S_DONE;

  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(sat_max(CNT_W));
  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || AVG_LOG2 < 1 || AVG_LOG2 > 4) begin : g_param_chk
    $error("jnwtr_ckmon: SYNC_STAGES must be 2..4 and AVG_LOG2 1..4");
  end

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cont;
  logic             w_edge;
  logic             w_sat;
  logic             w_fin;
  logic             w_fin_ovf;
  logic             w_inr;
  logic [CNT_W-1:0] w_len;
  logic [CNT_W-1:0] w_res;

`ifdef JNWTR_CKMON_AVG_EN
  logic [CNT_W+AVG_LOG2-1:0] r_acc;
  logic [CNT_W+AVG_LOG2-1:0] w_acc_nxt;
  logic [AVG_LOG2-1:0]       r_pidx;
  logic                      w_last;
`endif

  jnwtr_ckmon_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .ck       (ck),
    .rst      (rst),
    .din      (cki),
    .edge_det (w_edge)
  );

  // r_cnt holds (cycles since opening edge - 1), so the closing edge
  // measures r_cnt + 1 and an exact ck/N input reports N.
  assign w_sat = (r_cnt == c_cnt_max);
  assign w_len = r_cnt + c_one;

`ifdef JNWTR_CKMON_AVG_EN
  assign w_acc_nxt = r_acc + {{AVG_LOG2{1'b0}}, w_len};
  assign w_last    = &r_pidx;
`endif

  // Decide whether this cycle closes a measurement and with what result.
  always_comb begin
    w_fin     = 1'b0;
    w_fin_ovf = 1'b0;
    w_res     = '0;
    case (r_state)
      c_arm: begin
        if (!w_edge && w_sat) begin
          w_fin     = 1'b1;
          w_fin_ovf = 1'b1;
          w_res     = c_cnt_max;
        end
      end
      c_meas: begin
        if (w_sat) begin
          // Any saturated period ends the measurement as an overflow.
          w_fin     = 1'b1;
          w_fin_ovf = 1'b1;
          w_res     = c_cnt_max;
        end else if (w_edge) begin
`ifdef JNWTR_CKMON_AVG_EN
          if (w_last) begin
            w_fin = 1'b1;
            w_res = w_acc_nxt[CNT_W+AVG_LOG2-1:AVG_LOG2];
          end
`else
          w_fin = 1'b1;
          w_res = w_len;
`endif
        end
      end
      default: begin
      end
    endcase
  end

  // An inverted window (pmin > pmax) can never satisfy both terms.
  assign w_inr = !w_fin_ovf && (pmin <= w_res) && (w_res <= pmax);

  assign busy = (r_state != c_idle);

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_state <= c_idle;
      r_cnt   <= '0;
      r_cont  <= 1'b0;
      period  <= '0;
      valid   <= 1'b0;
      inrange <= 1'b0;
      ovf     <= 1'b0;
`ifdef JNWTR_CKMON_AVG_EN
      r_acc   <= '0;
      r_pidx  <= '0;
`endif
    end else if (abort) begin
      r_state <= c_idle;
      r_cnt   <= '0;
      valid   <= 1'b0;
`ifdef JNWTR_CKMON_AVG_EN
      r_acc   <= '0;
      r_pidx  <= '0;
`endif
    end else begin
      valid <= 1'b0;
      if (w_fin) begin
        period  <= w_res;
        ovf     <= w_fin_ovf;
        inrange <= w_inr;
        valid   <= 1'b1;
        r_state <= c_done;
        // The closing edge is also the opening edge of a continuous run.
        r_cnt   <= '0;
      end else begin
        case (r_state)
          c_idle: begin
            r_cnt <= '0;
            if (start) begin
              r_state <= c_arm;
              r_cont  <= cont;
            end
          end
          c_arm: begin
            if (w_edge) begin
              r_cnt   <= '0;
              r_state <= c_meas;
`ifdef JNWTR_CKMON_AVG_EN
              r_acc   <= '0;
              r_pidx  <= '0;
`endif
            end else begin
              r_cnt <= w_len;
            end
          end
          c_meas: begin
            if (w_edge) begin
              // Only reachable between sub-periods of an averaged result.
              r_cnt <= '0;
`ifdef JNWTR_CKMON_AVG_EN
              r_acc  <= w_acc_nxt;
              r_pidx <= r_pidx + AVG_LOG2'(1);
`endif
            end else begin
              r_cnt <= w_len;
            end
          end
          c_done: begin
            if (r_cont && !ovf) begin
              // The DONE cycle itself is the first cycle of the next period.
              r_state <= c_meas;
              r_cnt   <= c_one;
`ifdef JNWTR_CKMON_AVG_EN
              r_acc   <= '0;
              r_pidx  <= '0;
`endif
            end else begin
              r_state <= c_idle;
              r_cnt   <= '0;
            end
          end
          default: r_state <= c_idle;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jnwtr_ckmon.sv
`default_nettype none
// ============================================================================
// Module   : tb_jnwtr_ckmon
// Purpose  : Self-checking bench for jnwtr_ckmon (CNT_W=8). Table-driven
//            single measurements, hand-written corner sequences and random
//            period trains checked against a period-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jnwtr_ckmon;

  localparam int CW = 8;
  localparam int SS = 2;
  localparam int AL = 2;
`ifdef JNWTR_CKMON_AVG_EN
  localparam int GRP = 1 << AL;
`else
  localparam int GRP = 1;
`endif

  logic          ck = 1'b0;
  logic          rst;
  logic          cki;
  logic          start;
  logic          cont;
  logic          abort;
  logic [CW-1:0] pmin;
  logic [CW-1:0] pmax;
  logic [CW-1:0] period;
  logic          valid;
  logic          inrange;
  logic          ovf;
  logic          busy;

  jnwtr_ckmon #(
    .CNT_W       (CW),
    .SYNC_STAGES (SS),
    .AVG_LOG2    (AL)
  ) dut (
    .ck      (ck),
    .rst     (rst),
    .cki     (cki),
    .start   (start),
    .cont    (cont),
    .abort   (abort),
    .pmin    (pmin),
    .pmax    (pmax),
    .period  (period),
    .valid   (valid),
    .inrange (inrange),
    .ovf     (ovf),
    .busy    (busy)
  );

  always #5 ck = ~ck;

  typedef struct {
    int per;
    int inr;
    int ovf;
    int t;
    int span;
  } res_t;

  typedef struct {
    int p;
    int lo;
    int hi;
    int exp_p;
    int exp_inr;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  res_t got[$];
  res_t exp_q[$];
  res_t mon_r;

  always @(posedge ck) cyc <= cyc + 1;

  always @(negedge ck) begin
    if (valid) begin
      mon_r.per  = int'(period);
      mon_r.inr  = int'(inrange);
      mon_r.ovf  = int'(ovf);
      mon_r.t    = cyc;
      mon_r.span = 0;
      got.push_back(mon_r);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  // Rising edges of cki are spaced exactly by each listed period; a final
  // rise closes the last period.
  task automatic drive(input int ps[$]);
    foreach (ps[i]) begin
      cki = 1'b1;
      repeat (ps[i] / 2) step();
      cki = 1'b0;
      repeat (ps[i] - ps[i] / 2) step();
    end
    cki = 1'b1;
    repeat (2) step();
    cki = 1'b0;
  endtask

  // Reference model: results are the averages of consecutive groups of GRP
  // periods; one-shot mode keeps only the first group.
  function automatic void build_exp(input int ps[$], input bit c, input int lo, input int hi);
    int   ngrp;
    int   sum;
    res_t e;
    exp_q.delete();
    ngrp = ps.size() / GRP;
    if (!c && ngrp > 1) ngrp = 1;
    for (int g = 0; g < ngrp; g++) begin
      sum = 0;
      for (int k = 0; k < GRP; k++) sum += ps[g * GRP + k];
      e.per  = sum / GRP;
      e.ovf  = 0;
      e.inr  = (lo <= e.per && e.per <= hi) ? 1 : 0;
      e.t    = 0;
      e.span = sum;
      exp_q.push_back(e);
    end
  endfunction

  task automatic do_run(input int ps[$], input bit c, input int lo, input int hi);
    pmin = CW'(lo);
    pmax = CW'(hi);
    got.delete();
    cont  = c;
    start = 1'b1;
    step();
    start = 1'b0;
    cont  = 1'b0;
    check("busy_after_start", int'(busy), 1);
    repeat (2) step();
    drive(ps);
    repeat (8) step();
    if (c) begin
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("busy_after_abort", int'(busy), 0);
      repeat (20) step();
    end
    check("busy_idle", int'(busy), 0);
  endtask

  task automatic compare_run(input string tag, input bit c);
    check({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      check({tag, "_period"},  got[i].per, exp_q[i].per);
      check({tag, "_inrange"}, got[i].inr, exp_q[i].inr);
      check({tag, "_ovf"},     got[i].ovf, 0);
      if (c && i > 0) check({tag, "_spacing"}, got[i].t - got[i-1].t, exp_q[i].span);
    end
  endtask

  vec_t vecs[7];
  int   q[$];
  int   t0;

  initial begin
    rst   = 1'b1;
    cki   = 1'b0;
    start = 1'b0;
    cont  = 1'b0;
    abort = 1'b0;
    pmin  = '0;
    pmax  = '0;

    vecs[0] = '{p: 4,  lo: 3, hi: 5,   exp_p: 4,  exp_inr: 1};
    vecs[1] = '{p: 4,  lo: 5, hi: 9,   exp_p: 4,  exp_inr: 0};
    vecs[2] = '{p: 2,  lo: 2, hi: 2,   exp_p: 2,  exp_inr: 1};
    vecs[3] = '{p: 7,  lo: 0, hi: 6,   exp_p: 7,  exp_inr: 0};
    vecs[4] = '{p: 4,  lo: 6, hi: 3,   exp_p: 4,  exp_inr: 0};
    vecs[5] = '{p: 13, lo: 13, hi: 13, exp_p: 13, exp_inr: 1};
    vecs[6] = '{p: 30, lo: 0, hi: 255, exp_p: 30, exp_inr: 1};

    repeat (3) step();
    check("reset_period",  int'(period),  0);
    check("reset_valid",   int'(valid),   0);
    check("reset_inrange", int'(inrange), 0);
    check("reset_ovf",     int'(ovf),     0);
    check("reset_busy",    int'(busy),    0);
    rst = 1'b0;
    repeat (3) step();

    // Table-driven one-shot measurements (each period repeated so an
    // averaged build sees a full group of identical periods).
    for (int v = 0; v < 7; v++) begin
      q.delete();
      for (int k = 0; k < 4; k++) q.push_back(vecs[v].p);
      do_run(q, 1'b0, vecs[v].lo, vecs[v].hi);
      check("tbl_count", got.size(), 1);
      if (got.size() > 0) begin
        check("tbl_period",  got[0].per, vecs[v].exp_p);
        check("tbl_inrange", got[0].inr, vecs[v].exp_inr);
        check("tbl_ovf",     got[0].ovf, 0);
      end
      repeat (5) step();
    end

    // Periods 4,5,4,5: first period 4, or average 18>>2 = 4.
    q.delete();
    q.push_back(4); q.push_back(5); q.push_back(4); q.push_back(5);
    do_run(q, 1'b0, 3, 5);
    check("p4545_count", got.size(), 1);
    if (got.size() > 0) check("p4545_period", got[0].per, 4);
    repeat (5) step();

    // Continuous ck/6: back-to-back results spaced one group apart.
    q.delete();
    for (int k = 0; k < 8; k++) q.push_back(6);
    build_exp(q, 1'b1, 5, 7);
    do_run(q, 1'b1, 5, 7);
    compare_run("cont6", 1'b1);
    repeat (5) step();

    // Stuck-low cki: ARM saturates.
    pmin = '0;
    pmax = '1;
    got.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    t0 = cyc;
    for (int k = 0; k < 400 && got.size() == 0; k++) step();
    check("stuck_count", got.size(), 1);
    if (got.size() > 0) begin
      check("stuck_period",  got[0].per, 255);
      check("stuck_ovf",     got[0].ovf, 1);
      check("stuck_inrange", got[0].inr, 0);
      check("stuck_latency_ok", (got[0].t - t0 >= 250 && got[0].t - t0 <= 262) ? 1 : 0, 1);
    end
    step();
    check("stuck_busy", int'(busy), 0);
    repeat (5) step();

    // START while busy is ignored: exactly one result.
    q.delete();
    for (int k = 0; k < 4; k++) q.push_back(20);
    pmin = CW'(0);
    pmax = CW'(100);
    got.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    fork
      drive(q);
      begin
        repeat (3) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        start = 1'b1;
        step();
        start = 1'b0;
      end
    join
    repeat (10) step();
    check("rebusy_count", got.size(), 1);
    if (got.size() > 0) check("rebusy_period", got[0].per, 20);
    check("rebusy_idle", int'(busy), 0);
    repeat (5) step();

    // Reset in the middle of a measurement.
    got.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    cki = 1'b1;
    repeat (2) step();
    cki = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    #1;
    check("rst_period",  int'(period),  0);
    check("rst_valid",   int'(valid),   0);
    check("rst_inrange", int'(inrange), 0);
    check("rst_ovf",     int'(ovf),     0);
    check("rst_busy",    int'(busy),    0);
    step();
    rst = 1'b0;
    step();
    q.delete();
    for (int k = 0; k < 4; k++) q.push_back(4);
    do_run(q, 1'b0, 3, 5);
    check("post_rst_count", got.size(), 1);
    if (got.size() > 0) begin
      check("post_rst_period",  got[0].per, 4);
      check("post_rst_inrange", got[0].inr, 1);
    end
    repeat (5) step();

    // Random period trains against the reference model.
    for (int r = 0; r < 6; r++) begin
      bit c;
      int lo;
      int hi;
      c  = 1'($urandom_range(1, 0));
      lo = int'($urandom_range(45, 0));
      hi = int'($urandom_range(45, 0));
      q.delete();
      for (int k = 0; k < 8; k++) q.push_back(int'($urandom_range(40, 2)));
      build_exp(q, c, lo, hi);
      do_run(q, c, lo, hi);
      compare_run("rand", c);
      repeat (5) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
